amo_sequencer: RTL
==================

Name: amo_sequencer

Overview:
- Executes RV32A read-modify-write AMOs (AMOSWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU.W) as a stalling multi-cycle sequence.
- Reads the old word from data memory, computes the new value, and emits a single-cycle write on the AMO write interface.
- That write interface is consumed directly by the L0 cache write controller and by data memory.
- Returns the old word as the rd result. LR/SC are not handled here.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_amo_start  in  1  AMO instruction in MA, not stalled by another source; sampled only in IDLE
- i_amo_funct5  in  5  AMO funct5 (00001 SWAP, 00000 ADD, 00100 XOR, 01100 AND, 01000 OR, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU)
- i_address  in  XLEN  effective address (rs1)
- i_rs2_data  in  XLEN  operand (rs2)
- i_flush  in  1  pipeline flush; honoured only in IDLE
- o_mem_read_enable  out  1  read request to data memory
- o_mem_read_address  out  XLEN  read address (word aligned)
- i_mem_read_data  in  XLEN  read data, valid exactly 1 cycle after request
- o_write_enable  out  1  AMO write strobe to cache write controller/memory
- o_write_address  out  XLEN  AMO write address
- o_write_data  out  XLEN  AMO write data
- o_stall  out  1  pipeline stall request
- o_result  out  XLEN  old memory word for rd
- o_result_valid  out  1  one-cycle pulse when o_result is final
- o_misaligned  out  1  one-cycle pulse: address[1:0]!=0, no memory access performed
- o_illegal  out  1  one-cycle pulse: unsupported funct5, no memory access performed

Behaviour:
- States: IDLE, READ_WAIT, WRITE, DONE. Reset: state IDLE; all outputs 0; internal registers 0.
- IDLE, start accepted (i_amo_start & ~i_flush & aligned & legal):
  - o_stall=1 and o_mem_read_enable=1 combinationally in the same cycle.
  - o_mem_read_address = {i_address[XLEN-1:2], 2'b00}.
  - Latch address, funct5, rs2. Next state READ_WAIT.
- IDLE, start with i_flush=1: ignored; stays IDLE, no outputs.
- IDLE, start misaligned or illegal: o_misaligned/o_illegal pulses combinationally; no stall, no read; stays IDLE. Misaligned takes precedence when both apply.
- READ_WAIT: o_stall=1. Capture i_mem_read_data into old register; next WRITE.
- WRITE: o_stall=1 and o_write_enable=1 for exactly one cycle.
  - o_write_address = latched aligned address.
  - o_write_data = f(old, rs2). Next state DONE.
- Operation functions:
  - SWAP: rs2. ADD: old+rs2, modulo 2^32, carry dropped. XOR/AND/OR: bitwise.
  - MIN/MAX: signed compare. MINU/MAXU: unsigned compare. On equality either operand is returned (values identical).
- DONE: o_stall=0, o_result_valid=1, o_result=old; next IDLE.
  - o_result holds its value until the next AMO captures new data.
- o_write_address/o_write_data hold the last values when o_write_enable=0.
- Total latency: start cycle T to o_result_valid at T+3; o_stall high T..T+2.
- i_flush and i_amo_start are ignored outside IDLE; an accepted AMO always completes its write.
- A new start is accepted in the cycle after DONE (IDLE), never during DONE.
- MMIO addresses are not filtered here; downstream cache logic suppresses MMIO cache fills.
- Reset mid-sequence: return to IDLE next cycle, all strobes 0. A partial AMO is dropped with no write if reset lands before WRITE.

Test Plan:
- AMOADD.W at 0x100, mem=0x0000_0005, rs2=0x0000_0003 -> read pulse T; write_enable T+2, addr 0x100, data 0x8; result_valid T+3, result 0x5; stall T..T+2.
- AMOADD wrap: old 0xFFFF_FFFF, rs2 1 -> write_data 0x0000_0000, result 0xFFFF_FFFF.
- AMOMIN vs AMOMINU: old 0x8000_0000, rs2 0x1 -> MIN writes 0x8000_0000; MINU writes 0x0000_0001.
- AMOSWAP with address 0x102 -> o_misaligned pulse, no read, no write, o_stall never asserted.
- Back-to-back: AMOOR(old 0xF0, rs2 0x0F) then AMOXOR at the same address on the first IDLE cycle -> second reads 0xFF; 2nd write 0xFF^rs2; no start accepted during DONE.
- i_rst asserted in READ_WAIT -> next cycle IDLE, o_write_enable never pulses, o_stall=0. Separately, i_flush asserted in WRITE -> write still occurs.

Source files
------------

// File: rtl/amo_sequencer.sv
// amo_sequencer: stalling read-modify-write engine for RV32A AMOs (SWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU.W).
// Latency: start accepted at T, memory write at T+2, o_result_valid at T+3; o_stall high T..T+2.
// Backpressure: none accepted; the pipeline is held via o_stall, and start/flush are ignored outside IDLE.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_amo_start, i_amo_funct5         AMO request from MA and its operation select
//   i_address, i_rs2_data             effective address (rs1) and operand (rs2)
//   i_flush                           pipeline flush, only honoured in IDLE
//   o_mem_read_*, i_mem_read_data     data memory read port (data returns one cycle after the request)
//   o_write_*                         single-cycle AMO write to the cache write controller and memory
//   o_stall                           pipeline stall request
//   o_result, o_result_valid          old memory word for rd and its completion pulse
//   o_misaligned, o_illegal           rejection pulses; no memory access is made in either case
module amo_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_amo_start,
    input  logic [4:0]      i_amo_funct5,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    output logic            o_mem_read_enable,
    output logic [XLEN-1:0] o_mem_read_address,
    input  logic [XLEN-1:0] i_mem_read_data,
    output logic            o_write_enable,
    output logic [XLEN-1:0] o_write_address,
    output logic [XLEN-1:0] o_write_data,
    output logic            o_stall,
    output logic [XLEN-1:0] o_result,
    output logic            o_result_valid,
    output logic            o_misaligned,
    output logic            o_illegal
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [4:0]      funct5_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] wr_addr_q;
    logic [XLEN-1:0] wr_data_q;

    logic funct_legal;
    logic aligned;
    logic req;
    logic accept;

    function automatic logic [XLEN-1:0] amo_op(input logic [4:0] f5,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] operand);
        logic [XLEN-1:0] res;
        res = operand;
        case (f5)
            F5_SWAP: res = operand;
            F5_ADD:  res = old + operand;
            F5_XOR:  res = old ^ operand;
            F5_AND:  res = old & operand;
            F5_OR:   res = old | operand;
            F5_MIN:  res = ($signed(old) < $signed(operand)) ? old : operand;
            F5_MAX:  res = ($signed(old) > $signed(operand)) ? old : operand;
            F5_MINU: res = (old < operand) ? old : operand;
            F5_MAXU: res = (old > operand) ? old : operand;
            default: res = operand;
        endcase
        return res;
    endfunction

    always_comb begin
        funct_legal = 1'b0;
        case (i_amo_funct5)
            F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: funct_legal = 1'b1;
            default:                          funct_legal = 1'b0;
        endcase
    end

    // Requests are only looked at in IDLE and outside reset; a flush kills
    // the request outright, including its misaligned/illegal reporting.
    assign aligned = (i_address[1:0] == 2'b00);
    assign req     = (state == IDLE) && !i_rst && i_amo_start && !i_flush;
    assign accept  = req && aligned && funct_legal;

    always_comb begin
        state_nxt          = state;
        o_mem_read_enable  = 1'b0;
        o_mem_read_address = '0;
        o_stall            = 1'b0;
        o_write_enable     = 1'b0;
        o_result_valid     = 1'b0;
        o_misaligned       = 1'b0;
        o_illegal          = 1'b0;
        case (state)
            IDLE: begin
                o_misaligned = req && !aligned;
                o_illegal    = req && aligned && !funct_legal;
                if (accept) begin
                    o_mem_read_enable  = 1'b1;
                    o_mem_read_address = {i_address[XLEN-1:2], 2'b00};
                    o_stall            = 1'b1;
                    state_nxt          = READ_WAIT;
                end
            end
            READ_WAIT: begin
                o_stall   = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                o_stall        = 1'b1;
                o_write_enable = 1'b1;
                state_nxt      = DONE;
            end
            DONE: begin
                o_result_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            rs2_q     <= '0;
            funct5_q  <= '0;
            old_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= {i_address[XLEN-1:2], 2'b00};
                rs2_q    <= i_rs2_data;
                funct5_q <= i_amo_funct5;
            end
            // The new value is computed straight off the read data so the
            // write cycle drives registered address/data, which then hold
            // until the next AMO reaches this point.
            if (state == READ_WAIT) begin
                old_q     <= i_mem_read_data;
                wr_addr_q <= addr_q;
                wr_data_q <= amo_op(funct5_q, i_mem_read_data, rs2_q);
            end
        end
    end

    assign o_write_address = wr_addr_q;
    assign o_write_data    = wr_data_q;
    assign o_result        = old_q;

endmodule
